fp_vector_accum_ctrl: RTL and testbench
=======================================

Name: fp_vector_accum_ctrl

Overview:
- Initiator/sequencer that drives the 4-lane FP12 vector adder (1 sign, 5 exp, 6 mant) from the operand side.
- Accepts a stream of 4-lane vectors over valid/ready and issues (accumulator, new vector) pairs to the adder's in_valid port.
- Collects each adder result on add_res_valid and presents the final lane-wise sum on an output valid/ready port.
- Sits between the tile's operand buffer and the fixed-latency adder.

Parameters:
- EXP_BITS, 5, exponent width per lane.
- MANT_BITS, 6, mantissa width per lane.
- LEN_BITS, 8, width of the vector-count field.
- ADD_LATENCY, 3, cycles from add_valid high to add_res_valid high in the attached adder.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a reduction; ignored while busy=1.
- len  in  LEN_BITS  number of vectors to sum; sampled on an accepted start.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input vector accepted when in_valid & in_ready.
- in_vec  in  4*W  lanes {a,b,c,d}, with a in the MSBs; W = EXP_BITS+MANT_BITS+1.
- add_valid  out  1  issue strobe to the adder's in_valid.
- add_op1  out  4*W  accumulator lanes, driven to the adder's *_1 inputs.
- add_op2  out  4*W  new-vector lanes, driven to the adder's *_2 inputs.
- add_res_valid  in  1  adder out_valid.
- add_res  in  4*W  adder {a_out,b_out,c_out,d_out}.
- out_valid  out  1  sum available.
- out_ready  in  1  consumer accepts the sum.
- out_vec  out  4*W  final sum.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error; cleared by an accepted start.

Behaviour:
- Reset (asynchronous) values:
  - State = IDLE.
  - All outputs 0: in_ready, add_valid, add_op1, add_op2, out_valid, out_vec, busy, err.
  - Internal accumulator, remaining counter and watchdog timer = 0.
  - Reset asserted mid-reduction aborts it; no partial output is produced.
- IDLE:
  - On start: latch len, clear err.
  - len==0 -> DONE with accumulator = all-zero vector.
  - Otherwise -> FIRST with remaining = len.
- FIRST:
  - in_ready=1.
  - On accept: accumulator <= in_vec, remaining <= remaining-1.
  - If remaining was 1 -> DONE, else -> ACC.
- ACC:
  - in_ready=1.
  - On accept, at the next edge: add_op1 <= accumulator, add_op2 <= in_vec, add_valid <= 1 for exactly one cycle, timer <= 0; -> WAIT.
  - add_op1/add_op2 hold their values after the issue.
- WAIT:
  - in_ready=0; timer increments each cycle.
  - On add_res_valid: accumulator <= add_res, remaining <= remaining-1.
  - If remaining was 1 -> DONE, else -> ACC.
  - If timer reaches ADD_LATENCY+3 without add_res_valid: err <= 1, -> IDLE, no output.
- DONE:
  - out_valid=1; out_vec = accumulator, held stable while out_ready=0.
  - On out_ready -> IDLE; out_valid drops the following cycle.
- Strobe rules:
  - add_res_valid outside WAIT is spurious: sets err and is otherwise ignored; state is unchanged.
  - start while busy has no effect.
- Timing:
  - Accept in ACC at cycle t -> add_valid at t+1 -> result at t+1+ADD_LATENCY -> back in ACC at t+2+ADD_LATENCY.
  - Throughput is one add per ADD_LATENCY+2 cycles.
  - With len=N and in_valid held high, out_valid rises (N-1)*(ADD_LATENCY+2)+2 cycles after start.
- No arithmetic is performed in this block; lanes pass through bit-exact.
- remaining is LEN_BITS wide and never decrements below 0.

Decomposition:
- Shared package holds:
  - FP12 field widths (EXP_BITS, MANT_BITS) and derived W.
  - LANES=4 and the lane packing order {a,b,c,d}.
  - State encoding: IDLE, FIRST, ACC, WAIT, DONE.
  - Test-bench constants FP12_ONE=0x3C0, FP12_TWO=0x400, FP12_THREE=0x420.
- Keep the block flat; the watchdog is a single counter with a compare and does not warrant a sub-module.

Test Plan:
- len=3, inputs all lanes 0x3C0, in_valid held high, behavioural adder with latency 3 -> out_vec all lanes 0x420; out_valid rises 12 cycles after start; add_valid pulses exactly twice.
- len=1, in_vec lanes {0x400,0x3C0,0x000,0xBC0} -> out_vec identical; add_valid never asserted.
- len=0 -> out_valid=1 two cycles after start with out_vec=0; in_ready stays 0 throughout.
- out_ready held low for 5 cycles in DONE -> out_vec stable, out_valid stays high; second start pulse during DONE is ignored.
- Adder model never returns add_res_valid -> err=1 ADD_LATENCY+3 cycles after add_valid; state returns to IDLE; next start clears err.
- rst asserted in WAIT with add_res_valid arriving the same cycle -> all outputs 0 immediately; no out_valid afterwards; a fresh len=2 reduction completes correctly.

Source files
------------

// File: rtl/fp_vector_accum_ctrl_pkg.sv
// Shared types and constants for the FP12 vector accumulation sequencer.
// Lanes are packed {a,b,c,d} with lane a in the most significant bits.
package fp_vector_accum_ctrl_pkg;

  localparam int EXP_BITS    = 5;
  localparam int MANT_BITS   = 6;
  localparam int W           = EXP_BITS + MANT_BITS + 1;
  localparam int LANES       = 4;
  localparam int VEC_W       = LANES * W;
  localparam int LEN_BITS    = 8;
  localparam int ADD_LATENCY = 3;
  localparam int TIMEOUT     = ADD_LATENCY + 3;
  localparam int TMR_BITS    = 4;

  typedef logic [W-1:0]     fp12_t;
  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_ACC   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Last timer value at which a missing adder result is still tolerated
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);

  localparam fp12_t FP12_ONE   = 12'h3C0;
  localparam fp12_t FP12_TWO   = 12'h400;
  localparam fp12_t FP12_THREE = 12'h420;

  function automatic vec_t pack_lanes(input fp12_t a, input fp12_t b,
                                      input fp12_t c, input fp12_t d);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/fp_vector_accum_ctrl_if.sv
// Operand, adder and result handshake bundle for fp_vector_accum_ctrl.
// The slave modport is the sequencer's view; master is the surrounding tile.
interface fp_vector_accum_ctrl_if;
  import fp_vector_accum_ctrl_pkg::*;

  logic                start;
  logic [LEN_BITS-1:0] len;
  logic                in_valid;
  logic                in_ready;
  vec_t                in_vec;
  logic                add_valid;
  vec_t                add_op1;
  vec_t                add_op2;
  logic                add_res_valid;
  vec_t                add_res;
  logic                out_valid;
  logic                out_ready;
  vec_t                out_vec;
  logic                busy;
  logic                err;

  modport master (
    output start, len, in_valid, in_vec, add_res_valid, add_res, out_ready,
    input  in_ready, add_valid, add_op1, add_op2, out_valid, out_vec, busy, err
  );

  modport slave (
    input  start, len, in_valid, in_vec, add_res_valid, add_res, out_ready,
    output in_ready, add_valid, add_op1, add_op2, out_valid, out_vec, busy, err
  );

endinterface

// File: rtl/fp_vector_accum_ctrl.sv
// Sequencer that folds a stream of 4-lane FP12 vectors through an external
// fixed-latency adder and presents the lane-wise sum; lanes pass bit-exact.
module fp_vector_accum_ctrl
  import fp_vector_accum_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fp_vector_accum_ctrl_if.slave bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  vec_t                r_acc;
  vec_t                w_acc_nxt;
  logic [LEN_BITS-1:0] r_rem;
  logic [LEN_BITS-1:0] w_rem_nxt;
  logic [LEN_BITS-1:0] w_rem_dec;
  logic [TMR_BITS-1:0] r_timer;
  logic [TMR_BITS-1:0] w_timer_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic                w_spurious;
  logic                w_issue;
  logic                w_accept;
  logic                w_last;
  logic                r_in_ready;
  logic                r_add_valid;
  logic                r_out_valid;
  logic                r_busy;
  vec_t                r_add_op1;
  vec_t                r_add_op2;
  vec_t                r_out_vec;

  assign w_accept   = r_in_ready & bus.in_valid;
  assign w_last     = (r_rem <= LEN_BITS'(1));
  assign w_rem_dec  = (r_rem != {LEN_BITS{1'b0}}) ? (r_rem - LEN_BITS'(1)) : {LEN_BITS{1'b0}};
  assign w_spurious = bus.add_res_valid & (r_state != ST_WAIT);

  assign bus.in_ready  = r_in_ready;
  assign bus.add_valid = r_add_valid;
  assign bus.add_op1   = r_add_op1;
  assign bus.add_op2   = r_add_op2;
  assign bus.out_valid = r_out_valid;
  assign bus.out_vec   = r_out_vec;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_timer_nxt = r_timer;
    w_err_nxt   = r_err;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_err_nxt = 1'b0;
          w_rem_nxt = bus.len;
          if (bus.len == {LEN_BITS{1'b0}}) begin
            w_acc_nxt   = {VEC_W{1'b0}};
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FIRST;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIRST: begin
        if (w_accept) begin
          w_acc_nxt   = bus.in_vec;
          w_rem_nxt   = w_rem_dec;
          w_state_nxt = w_last ? ST_DONE : ST_ACC;
        end else begin
          w_state_nxt = ST_FIRST;
        end
      end
      ST_ACC: begin
        if (w_accept) begin
          w_issue     = 1'b1;
          w_timer_nxt = {TMR_BITS{1'b0}};
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_WAIT: begin
        // A result arriving on the final watchdog cycle still wins
        if (bus.add_res_valid) begin
          w_acc_nxt   = bus.add_res;
          w_rem_nxt   = w_rem_dec;
          w_state_nxt = w_last ? ST_DONE : ST_ACC;
        end else if (r_timer == TMR_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_BITS'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers; outputs are registered from the next state so they align with r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= {VEC_W{1'b0}};
      r_rem       <= {LEN_BITS{1'b0}};
      r_timer     <= {TMR_BITS{1'b0}};
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_add_valid <= 1'b0;
      r_add_op1   <= {VEC_W{1'b0}};
      r_add_op2   <= {VEC_W{1'b0}};
      r_out_vec   <= {VEC_W{1'b0}};
    end else begin
      r_acc       <= w_acc_nxt;
      r_rem       <= w_rem_nxt;
      r_timer     <= w_timer_nxt;
      r_err       <= w_err_nxt | w_spurious;
      r_in_ready  <= (w_state_nxt == ST_FIRST) || (w_state_nxt == ST_ACC);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_add_valid <= w_issue;
      if (w_issue) begin
        r_add_op1 <= r_acc;
        r_add_op2 <= bus.in_vec;
      end
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
        r_out_vec <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fp_vector_accum_ctrl.sv
// Directed bench for fp_vector_accum_ctrl with a behavioural 3-cycle FP12 adder
// and a queue of expected sums checked at each output handshake.
module tb_fp_vector_accum_ctrl;
  import fp_vector_accum_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic adder_mute = 1'b0;
  logic p1 = 1'b0;
  logic p2 = 1'b0;
  vec_t d1;
  vec_t d2;

  int   n_vec   = 0;
  int   n_miss  = 0;
  int   n_issue = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  fp_vector_accum_ctrl_if bus ();

  fp_vector_accum_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Same-sign FP12 add with truncation; enough for the positive test values
  function automatic fp12_t fp_add(input fp12_t x, input fp12_t y);
    fp12_t      a;
    fp12_t      b;
    logic [4:0] d;
    logic [6:0] ma;
    logic [6:0] mb;
    logic [7:0] s;
    if (x[10:0] == 11'd0) return y;
    if (y[10:0] == 11'd0) return x;
    if (x[10:6] >= y[10:6]) begin a = x; b = y; end
    else begin a = y; b = x; end
    d  = a[10:6] - b[10:6];
    ma = {1'b1, a[5:0]};
    mb = {1'b1, b[5:0]} >> d;
    s  = {1'b0, ma} + {1'b0, mb};
    if (s[7]) return {a[11], a[10:6] + 5'd1, s[6:1]};
    return {a[11], a[10:6], s[5:0]};
  endfunction

  function automatic vec_t vadd(input vec_t x, input vec_t y);
    return {fp_add(x[47:36], y[47:36]), fp_add(x[35:24], y[35:24]),
            fp_add(x[23:12], y[23:12]), fp_add(x[11:0], y[11:0])};
  endfunction

  // Behavioural adder: result valid ADD_LATENCY cycles after add_valid
  always @(posedge clk) begin
    p1 <= bus.add_valid & ~adder_mute;
    d1 <= vadd(bus.add_op1, bus.add_op2);
    p2 <= p1;
    d2 <= d1;
    bus.add_res_valid <= p2;
    bus.add_res       <= d2;
  end

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: score any output handshake, then advance and count issues
  task automatic tick();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_miss++;
        $error("FAIL out_unexpected: observed out_valid 1, expected 0");
      end
      if (exp_q.size() != 0) chk("out_vec", bus.out_vec, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (bus.add_valid === 1'b1) n_issue++;
  endtask

  task automatic start_red(input logic [LEN_BITS-1:0] n);
    bus.len   = n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_until_out(input int budget, output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int   cyc;
    vec_t v;
    vec_t e;
    logic saw;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = 48'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_add_valid", bus.add_valid, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk("rst_out_vec", bus.out_vec, 48'd0);
    chk("rst_add_op1", bus.add_op1, 48'd0);
    chk("rst_add_op2", bus.add_op2, 48'd0);
    rst = 1'b0;
    tick();

    // len=3 of 1.0 with the consumer stalled, plus an ignored start in DONE
    v = pack_lanes(FP12_ONE, FP12_ONE, FP12_ONE, FP12_ONE);
    e = vadd(vadd(v, v), v);
    exp_q.push_back(e);
    bus.in_vec   = v;
    bus.in_valid = 1'b1;
    n_issue      = 0;
    start_red(8'd3);
    run_until_out(40, cyc);
    chki("len3_latency", cyc + 1, 12);
    chki("len3_issues", n_issue, 2);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 1);
      bus.len   = 8'd1;
      tick();
      chk1("hold_valid", bus.out_valid, 1'b1);
      chk("hold_vec", bus.out_vec, e);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk1("len3_valid_drop", bus.out_valid, 1'b0);
    chk1("len3_idle", bus.busy, 1'b0);

    // len=1: lanes pass straight through, no adder traffic
    v = pack_lanes(FP12_TWO, FP12_ONE, 12'h000, 12'hBC0);
    exp_q.push_back(v);
    bus.in_vec = v;
    n_issue    = 0;
    start_red(8'd1);
    run_until_out(20, cyc);
    chki("len1_latency", cyc + 1, 2);
    tick();
    chki("len1_issues", n_issue, 0);
    chk1("len1_idle", bus.busy, 1'b0);

    // len=0: zero sum, input side never opened
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.push_back(48'd0);
    saw = 1'b0;
    start_red(8'd0);
    saw = saw | bus.in_ready;
    tick();
    saw = saw | bus.in_ready;
    chk1("len0_valid", bus.out_valid, 1'b1);
    chk("len0_vec", bus.out_vec, 48'd0);
    chk1("len0_in_ready", saw, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk1("len0_idle", bus.busy, 1'b0);

    // Adder never answers: watchdog error, back to IDLE, next start clears it
    adder_mute   = 1'b1;
    v = pack_lanes(FP12_ONE, FP12_ONE, FP12_ONE, FP12_ONE);
    bus.in_vec   = v;
    bus.in_valid = 1'b1;
    start_red(8'd2);
    cyc = 0;
    while (bus.add_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk1("wd_issue", bus.add_valid, 1'b1);
    cyc = 0;
    while (bus.err !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chki("wd_latency", cyc, ADD_LATENCY + 3);
    chk1("wd_idle", bus.busy, 1'b0);
    chk1("wd_no_out", bus.out_valid, 1'b0);
    adder_mute = 1'b0;
    exp_q.push_back(v);
    start_red(8'd1);
    chk1("err_clear", bus.err, 1'b0);
    run_until_out(20, cyc);
    tick();

    // Reset lands in WAIT on the cycle the adder result arrives
    start_red(8'd3);
    cyc = 0;
    while (bus.add_res_valid !== 1'b1 && cyc < 30) begin tick(); cyc++; end
    chk1("abort_in_wait", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_in_ready", bus.in_ready, 1'b0);
    chk1("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_add_op1", bus.add_op1, 48'd0);
    chk("abort_out_vec", bus.out_vec, 48'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      saw = saw | bus.out_valid;
    end
    chk1("abort_no_out", saw, 1'b0);

    // Fresh len=2 reduction after the abort
    v = pack_lanes(FP12_TWO, FP12_ONE, FP12_THREE, 12'h000);
    exp_q.push_back(vadd(v, v));
    bus.in_vec = v;
    n_issue    = 0;
    start_red(8'd2);
    run_until_out(30, cyc);
    chki("len2_latency", cyc + 1, 7);
    tick();
    chki("len2_issues", n_issue, 1);
    chki("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
